ram_sync_param: RTL and testbench
=================================

# ram_sync_param

Parametrised single-clock synchronous RAM that generalises the fixed-size 1K/16K/32K and dual-read blocks into one module. It is configurable in address width, data width, read-during-write behaviour and clear value, and has an optional second read-only port. A built-in clear engine fills the array with a known value after reset, and `busy` is exported. CPU memory and video RAM instances in the Jupiter Ace top level use this block.

## Interface
- `AW`, 10, address width; depth is 2^AW words.
- `DW`, 8, data width.
- `WRITE_FIRST`, 0, read-during-write on port 1: 0 returns old data, 1 returns `din`.
- `CLEAR_ON_RESET`, 1, 1 runs the clear engine after reset; 0 leaves contents untouched.
- `CLEAR_VALUE`, 0, DW-bit word written to every location by the clear engine.
- `clk`  in  1  single clock; all activity on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ce`  in  1  chip enable; gates writes only.
- `a`  in  AW  port 1 address (read/write).
- `we`  in  1  write enable; a write occurs when `we & ce & ~busy`.
- `din`  in  DW  write data.
- `dout`  out  DW  port 1 registered read data.
- `a2`  in  AW  port 2 address (read-only).
- `dout2`  out  DW  port 2 registered read data.
- `busy`  out  1  clear engine active; user writes ignored.

## Operation
- States: `CLEAR`, `RUN`. A clear address counter `cnt` is AW bits wide.
- Any edge with `rst_n`=0:
  - `dout`<=0 and `dout2`<=0.
  - `cnt`<=0.
  - With CLEAR_ON_RESET=1: state<=`CLEAR`, `busy`<=1.
  - With CLEAR_ON_RESET=0: state<=`RUN`, `busy`<=0.
  - No array write occurs.
- `CLEAR` (with `rst_n`=1), each edge:
  - mem[`cnt`]<=CLEAR_VALUE and `cnt`<=`cnt`+1.
  - When `cnt`=2^AW-1: state<=`RUN`, `busy`<=0, and `cnt` wraps to 0.
  - `dout` and `dout2` are held at 0.
  - `we`, `ce`, `din`, `a` and `a2` are ignored.
- `RUN`, each edge:
  - `dout2`<=mem[`a2`] (always the pre-edge contents).
  - If `we & ce`: mem[`a`]<=`din`.
  - `dout`<=`din` when WRITE_FIRST=1 and `we & ce`; otherwise `dout`<=mem[`a`] (old data).
  - Reads occur every cycle regardless of `ce`.
- Simultaneous events:
  - A write on port 1 and a read on port 2 at the same address in the same cycle: `dout2` returns the old data; the new data is visible from the next read.
- Reset mid-clear: the clear restarts from address 0, and the full 2^AW cycles run again.
- Reset in `RUN`: array contents are overwritten only if CLEAR_ON_RESET=1.
- No arithmetic on data. Addresses are used as-is, with no wrap or offset.

## Timing
- Read latency is 1 cycle: an address presented before edge N yields data on `dout`/`dout2` after edge N.
- Write takes effect at edge N. A read of the same address issued for edge N+1 returns the new data after N+1.
- Clear duration: with `rst_n` released before edge R, clear writes occur at edges R..R+2^AW-1.
  - `busy` falls after edge R+2^AW-1.
  - The first accepted user write is at edge R+2^AW.
- `busy`, `dout` and `dout2` are registered outputs. There are no combinational input-to-output paths.
- Reset values: `dout`=0, `dout2`=0, `busy`=CLEAR_ON_RESET.

## Test plan
All tests use AW=4, DW=8 unless noted.
- **Clear:** CLEAR_VALUE=8'hA5. Hold `rst_n`=0 for 2 cycles, release.
  - `busy` stays 1 for exactly 16 edges, then goes 0.
  - Reading all 16 addresses on both ports returns 8'hA5.
- **Write ignored while busy:** `we`=`ce`=1, `a`=3, `din`=8'h5A applied during `CLEAR`.
  - After clear, mem[3] reads CLEAR_VALUE, not 8'h5A.
- **Read-during-write, old data:** WRITE_FIRST=0, mem[7]=8'h11. Write 8'h22 to `a`=7 with `a2`=7 on the same edge.
  - `dout`=8'h11 and `dout2`=8'h11 on that edge.
  - 8'h22 is returned on both ports on the next edge.
- **Read-during-write, write-first:** repeat the previous test with WRITE_FIRST=1.
  - `dout`=8'h22 and `dout2`=8'h11 on the write edge.
- **`ce` gating:** `we`=1, `ce`=0, `a`=2, `din`=8'hFF.
  - mem[2] is unchanged.
  - `dout` still shows mem[2] after 1 cycle.
- **Reset mid-clear:** assert `rst_n`=0 at clear cycle 9, release one cycle later.
  - `busy` stays high for another full 16 edges.
  - All locations read CLEAR_VALUE.
  - `dout`/`dout2` are 0 throughout `CLEAR`.

Source files
------------

// File: rtl/ram_sync_param.sv
// Parametrised single-clock RAM with an optional second read port and a
// post-reset clear engine that fills every word with CLEAR_VALUE.
module ram_sync_param #(
  parameter int               AW             = 10,
  parameter int               DW             = 8,
  parameter int               WRITE_FIRST    = 0,
  parameter int               CLEAR_ON_RESET = 1,
  parameter logic [DW-1:0]    CLEAR_VALUE    = '0
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          ce_i,
  input  logic [AW-1:0] a_i,
  input  logic          we_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  input  logic [AW-1:0] a2_i,
  output logic [DW-1:0] dout2_o,
  output logic          busy_o
);

  localparam int            Depth  = 2 ** AW;
  localparam logic [AW-1:0] CntMax = '1;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dout_q, dout2_q;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic [DW-1:0] mem [0:Depth-1];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While clearing, the counter owns the write port and user writes are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    memWe   = 1'b0;
    memAddr = a_i;
    memData = din_i;
    if (state_q == CLEAR) begin
      memWe   = rst_n_i;
      memAddr = cnt_q;
      memData = CLEAR_VALUE;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CntMax) begin
        state_d = RUN;
      end
    end else begin
      memWe = rst_n_i & we_i & ce_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (memWe) begin
      mem[memAddr] <= memData;
    end
  end

  // Reads sample the array before this edge's write lands, giving old data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || state_q == CLEAR) begin
      dout_q  <= '0;
      dout2_q <= '0;
    end else begin
      dout2_q <= mem[a2_i];
      if (WRITE_FIRST != 0 && we_i && ce_i) begin
        dout_q <= din_i;
      end else begin
        dout_q <= mem[a_i];
      end
    end
  end

  assign dout_o  = dout_q;
  assign dout2_o = dout2_q;
  assign busy_o  = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_sync_param.sv
// Directed bench for ram_sync_param: clear engine, read-during-write on both
// ports, chip-enable gating, reset during clear, and the no-clear variant.
module tb_ram_sync_param;

  logic       clk;
  logic       rstN;
  logic       ce;
  logic [3:0] a;
  logic       we;
  logic [7:0] din;
  logic [3:0] a2;

  logic [7:0] w0Dout, w0Dout2, w1Dout, w1Dout2, ncDout, ncDout2;
  logic       w0Busy, w1Busy, ncBusy;

  int total = 0;
  int bad   = 0;

  // Old-data variant with clear to A5.
  ram_sync_param #(.AW(4), .DW(8), .WRITE_FIRST(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) dutW0 (
    .clk_i(clk), .rst_n_i(rstN), .ce_i(ce), .a_i(a), .we_i(we), .din_i(din),
    .dout_o(w0Dout), .a2_i(a2), .dout2_o(w0Dout2), .busy_o(w0Busy)
  );

  ram_sync_param #(.AW(4), .DW(8), .WRITE_FIRST(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) dutW1 (
    .clk_i(clk), .rst_n_i(rstN), .ce_i(ce), .a_i(a), .we_i(we), .din_i(din),
    .dout_o(w1Dout), .a2_i(a2), .dout2_o(w1Dout2), .busy_o(w1Busy)
  );

  // No clear engine: accepts writes straight after reset and keeps contents across reset.
  ram_sync_param #(.AW(4), .DW(8), .WRITE_FIRST(0), .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'hA5)) dutNc (
    .clk_i(clk), .rst_n_i(rstN), .ce_i(ce), .a_i(a), .we_i(we), .din_i(din),
    .dout_o(ncDout), .a2_i(a2), .dout2_o(ncDout2), .busy_o(ncBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic w, input logic c,
                               input logic [3:0] ad, input logic [7:0] d,
                               input logic [3:0] ad2);
    rstN = r;
    we   = w;
    ce   = c;
    a    = ad;
    din  = d;
    a2   = ad2;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 8'h5A, 4'd0);
    @(negedge clk);

    // Reset held for two edges, with a write to address 3 pending.
    tick();
    tick();
    checkOutput("rst_dout",   w0Dout,  8'h00);
    checkOutput("rst_dout2",  w0Dout2, 8'h00);
    checkOutput("rst_busy",   {7'd0, w0Busy}, 8'h01);
    checkOutput("rst_busyWF", {7'd0, w1Busy}, 8'h01);
    checkOutput("rst_busyNC", {7'd0, ncBusy}, 8'h00);

    // Release reset: busy holds for exactly 16 edges; the write to 3 must be dropped.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 8'h5A, 4'd3);
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput($sformatf("clr_busy%0d", i), {7'd0, w0Busy}, (i < 16) ? 8'h01 : 8'h00);
      checkOutput($sformatf("clr_dout%0d", i), w0Dout, 8'h00);
      checkOutput($sformatf("clr_dout2WF%0d", i), w1Dout2, 8'h00);
    end

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 4'(i), 8'h00, 4'(15 - i));
      tick();
      checkOutput($sformatf("rd_dout%0d", i),  w0Dout,  8'hA5);
      checkOutput($sformatf("rd_dout2%0d", i), w0Dout2, 8'hA5);
      if (i == 3) begin
        checkOutput("rd_doutWF3", w1Dout, 8'hA5);
        checkOutput("rd_doutNC3", ncDout, 8'h5A);
      end
      if (i == 12) begin
        checkOutput("rd_dout2NC3", ncDout2, 8'h5A);
      end
    end

    // Read-during-write at address 7 on both ports.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 8'h11, 4'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 8'h22, 4'd7);
    tick();
    checkOutput("rdw_dout_old",  w0Dout,  8'h11);
    checkOutput("rdw_dout2_old", w0Dout2, 8'h11);
    checkOutput("rdw_dout_wf",   w1Dout,  8'h22);
    checkOutput("rdw_dout2_wf",  w1Dout2, 8'h11);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, 8'h00, 4'd7);
    tick();
    checkOutput("rdw_next_dout",    w0Dout,  8'h22);
    checkOutput("rdw_next_dout2",   w0Dout2, 8'h22);
    checkOutput("rdw_next_doutWF",  w1Dout,  8'h22);
    checkOutput("rdw_next_dout2WF", w1Dout2, 8'h22);

    // Write with ce low must not land, and write-first must not forward din.
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 8'hFF, 4'd2);
    tick();
    checkOutput("ce_dout",   w0Dout, 8'hA5);
    checkOutput("ce_doutWF", w1Dout, 8'hA5);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd2, 8'h00, 4'd2);
    tick();
    checkOutput("ce_after_dout",    w0Dout,  8'hA5);
    checkOutput("ce_after_dout2WF", w1Dout2, 8'hA5);

    // Reset, then reset again nine edges into the clear.
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd7, 8'h00, 4'd7);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 8'h33, 4'd7);
    for (int i = 1; i <= 9; i++) begin
      tick();
      checkOutput($sformatf("mid_busy%0d", i), {7'd0, w0Busy}, 8'h01);
      checkOutput($sformatf("mid_dout%0d", i), w0Dout, 8'h00);
      checkOutput($sformatf("mid_doutWF%0d", i), w1Dout, 8'h00);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 8'h33, 4'd7);
    tick();
    checkOutput("mid_rst_busy",   {7'd0, w0Busy}, 8'h01);
    checkOutput("mid_rst_busyNC", {7'd0, ncBusy}, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 8'h33, 4'd7);
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput($sformatf("re_busy%0d", i), {7'd0, w0Busy}, (i < 16) ? 8'h01 : 8'h00);
      checkOutput($sformatf("re_dout2%0d", i), w0Dout2, 8'h00);
      checkOutput($sformatf("re_doutWF%0d", i), w1Dout, 8'h00);
    end

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 4'(i), 8'h00, 4'(i));
      tick();
      checkOutput($sformatf("re_rd_dout%0d", i),    w0Dout,  8'hA5);
      checkOutput($sformatf("re_rd_dout2WF%0d", i), w1Dout2, 8'hA5);
      if (i == 3) checkOutput("re_rd_doutNC3", ncDout, 8'h5A);
      if (i == 7) checkOutput("re_rd_doutNC7", ncDout, 8'h33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
